// File: rtl/pipelined_right_shifter.sv
// ---------------------------------------------------------------------------
// pipelined_right_shifter
//   5-stage pipelined 32-bit right barrel shifter / rotator.
//   Stage k applies a right shift of 2^k when sel[k] is set. The fill bits
//   depend on mode:
//     00 logical  - zero fill
//     01 arith    - copies of the operand's bit 31
//     10 rotate   - bits leaving bit 0 re-enter at bit 31
//     11 reserved - treated as logical
//   Handshake: valid/ready on both ends. A single global stall
//   (out_valid & ~out_ready) freezes every stage, bubbles included.
//
// Ports
//   clock      rising-edge clock
//   resetn     asynchronous active-low reset
//   in_valid   input sample valid
//   in_ready   block can accept a sample this cycle
//   a          data to shift
//   sel        shift amount 0..31
//   mode       shift mode (see above)
//   out_valid  b holds a result
//   out_ready  downstream accepts b this cycle
//   b          shifted result
// ---------------------------------------------------------------------------

// One pipeline stage: registers data, sel, mode and valid, applying the
// 2^K shift selected by sel_in[K] on the way in.
module pipelined_right_shifter_stage #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5,
    parameter int K     = 0
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             adv,       // pipeline advances this cycle
    input  logic             load,      // capture payload (S0: only for real samples)
    input  logic             vld_in,
    input  logic [WIDTH-1:0] data_in,
    input  logic [SHW-1:0]   sel_in,
    input  logic [1:0]       mode_in,
    output logic             vld_out,
    output logic [WIDTH-1:0] data_out,
    output logic [SHW-1:0]   sel_out,
    output logic [1:0]       mode_out
);
    localparam int SH = 1 << K;

    logic [WIDTH-1:0] shifted;

    // Arithmetic fill uses data_in[WIDTH-1]: earlier arithmetic stages never
    // change the top bit, so it is still the original operand's sign.
    always_comb begin
        shifted = data_in;
        if (sel_in[K]) begin
            case (mode_in)
                2'b01:   shifted = $signed(data_in) >>> SH;
                2'b10:   shifted = {data_in[SH-1:0], data_in[WIDTH-1:SH]};
                default: shifted = data_in >> SH;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            vld_out  <= 1'b0;
            data_out <= '0;
            sel_out  <= '0;
            mode_out <= '0;
        end else if (adv) begin
            vld_out <= vld_in;
            // Bubbles entering S0 hold the old payload so the data stays deterministic.
            if (load) begin
                data_out <= shifted;
                sel_out  <= sel_in;
                mode_out <= mode_in;
            end
        end
    end
endmodule

module pipelined_right_shifter #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [SHW-1:0]   sel,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] b
);
    localparam int STAGES = SHW;

    // Index 0 is the input port, index k+1 is the output of stage k.
    logic [STAGES:0]            vld_pipe;
    logic [STAGES:0][WIDTH-1:0] data_pipe;
    logic [STAGES:0][SHW-1:0]   sel_pipe;
    logic [STAGES:0][1:0]       mode_pipe;

    logic stall;
    logic adv;

    assign stall    = vld_pipe[STAGES] & ~out_ready;
    assign adv      = ~stall;
    assign in_ready = adv;

    assign vld_pipe[0]  = in_valid;
    assign data_pipe[0] = a;
    assign sel_pipe[0]  = sel;
    assign mode_pipe[0] = mode;

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            pipelined_right_shifter_stage #(
                .WIDTH (WIDTH),
                .SHW   (SHW),
                .K     (k)
            ) u_stage (
                .clock    (clock),
                .resetn   (resetn),
                .adv      (adv),
                .load     ((k == 0) ? in_valid : 1'b1),
                .vld_in   (vld_pipe[k]),
                .data_in  (data_pipe[k]),
                .sel_in   (sel_pipe[k]),
                .mode_in  (mode_pipe[k]),
                .vld_out  (vld_pipe[k+1]),
                .data_out (data_pipe[k+1]),
                .sel_out  (sel_pipe[k+1]),
                .mode_out (mode_pipe[k+1])
            );
        end
    endgenerate

    assign out_valid = vld_pipe[STAGES];
    assign b         = data_pipe[STAGES];

    // The last stage's sel/mode copies have no consumer.
    logic unused_tail;
    assign unused_tail = ^{sel_pipe[STAGES], mode_pipe[STAGES]};
endmodule

// File: tb/tb_pipelined_right_shifter.sv
module tb_pipelined_right_shifter;
    logic        clock = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [4:0]  sel;
    logic [1:0]  mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] b;

    pipelined_right_shifter dut (
        .clock     (clock),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .sel       (sel),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .b         (b)
    );

    always #5 clock = ~clock;

    int          checks = 0;
    int          passed = 0;
    int          out_cnt = 0;
    int          in_cnt = 0;
    logic [31:0] exp_q[$];

    // Reference: shift within a 64-bit word, then keep the low half.
    function automatic logic [31:0] ref_shift(logic [31:0] x, logic [4:0] s, logic [1:0] m);
        logic [63:0] w;
        case (m)
            2'b01:   w = {{32{x[31]}}, x} >> s;
            2'b10:   w = {x, x} >> s;
            default: w = {32'h0, x} >> s;
        endcase
        return w[31:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic drive(input logic iv, input logic [31:0] ia, input logic [4:0] is,
                         input logic [1:0] im, input logic ordy);
        in_valid  = iv;
        a         = ia;
        sel       = is;
        mode      = im;
        out_ready = ordy;
    endtask

    // Called at a negedge with inputs driven; evaluates both handshakes
    // just before the next rising edge and ends at the following negedge.
    task automatic tick(output bit acc);
        #1;
        acc = in_valid && in_ready;
        if (acc) begin
            exp_q.push_back(ref_shift(a, sel, mode));
            in_cnt++;
        end
        if (out_valid && out_ready) begin
            out_cnt++;
            if (exp_q.size() == 0) check("spurious_out", {31'b0, out_valid}, 32'h0);
            else check("stream_b", b, exp_q.pop_front());
        end
        @(negedge clock);
    endtask

    task automatic drain(input int max_cyc);
        bit acc;
        int n = 0;
        drive(1'b0, 32'h0, 5'd0, 2'b00, 1'b1);
        while (exp_q.size() > 0 && n < max_cyc) begin
            tick(acc);
            n++;
        end
        check("drain_empty", exp_q.size(), 32'h0);
    endtask

    // One isolated sample: out_valid must rise exactly after the 5th edge
    // counted from acceptance and stay high for one cycle.
    task automatic single_latency(input string tag, input logic [31:0] ia,
                                  input logic [4:0] is, input logic [1:0] im,
                                  input logic [31:0] exp);
        bit acc;
        drive(1'b1, ia, is, im, 1'b1);
        tick(acc);
        check({tag, "_acc"}, {31'b0, acc}, 32'h1);
        for (int i = 0; i < 6; i++) begin
            check({tag, "_vld"}, {31'b0, out_valid}, {31'b0, (i == 4)});
            if (i == 4) check({tag, "_b"}, b, exp);
            drive(1'b0, 32'h0, 5'd0, 2'b00, 1'b1);
            tick(acc);
        end
        check({tag, "_empty"}, exp_q.size(), 32'h0);
    endtask

    initial begin
        bit          acc;
        logic [31:0] pa[8];
        logic [4:0]  ps[8];
        logic [1:0]  pm[8];
        logic [31:0] hold_b;
        logic [31:0] ra;
        int          j, stall_left, cyc, out0;
        bit          seen;

        // ---- reset state
        resetn = 1'b0;
        drive(1'b1, 32'hDEAD_BEEF, 5'd3, 2'b01, 1'b1);
        #2;
        check("rst_out_valid", {31'b0, out_valid}, 32'h0);
        check("rst_b", b, 32'h0);
        @(negedge clock);
        @(negedge clock);
        check("rst_ignore_in", {31'b0, out_valid}, 32'h0);
        resetn = 1'b1;
        drive(1'b0, 32'h0, 5'd0, 2'b00, 1'b1);
        #1;
        check("rst_in_ready", {31'b0, in_ready}, 32'h1);
        @(negedge clock);

        // ---- rotate, single sample
        single_latency("rot", 32'h0000_001F, 5'd5, 2'b10, 32'hF800_0000);

        // ---- logical then arithmetic back-to-back
        drive(1'b1, 32'h8000_0000, 5'd31, 2'b00, 1'b1);
        tick(acc);
        drive(1'b1, 32'h8000_0000, 5'd4, 2'b01, 1'b1);
        tick(acc);
        for (int i = 1; i < 7; i++) begin
            check("b2b_vld", {31'b0, out_valid}, {31'b0, (i == 4 || i == 5)});
            if (i == 4) check("b2b_logic", b, 32'h0000_0001);
            if (i == 5) check("b2b_arith", b, 32'hF800_0000);
            drive(1'b0, 32'h0, 5'd0, 2'b00, 1'b1);
            tick(acc);
        end

        // ---- six-sample rotate stream on consecutive cycles
        for (int i = 0; i < 12; i++) begin
            if (i < 6) drive(1'b1, (32'h20 << i) - 32'h1, 5'd5, 2'b10, 1'b1);
            else drive(1'b0, 32'h0, 5'd0, 2'b00, 1'b1);
            tick(acc);
            check("stream_vld", {31'b0, out_valid}, {31'b0, (i >= 4 && i <= 9)});
            if (i == 4) check("stream_first", b, 32'hF800_0000);
            if (i == 9) check("stream_last", b, 32'hF800_001F);
        end
        check("stream_empty", exp_q.size(), 32'h0);

        // ---- sel=0 passthrough
        single_latency("pass", 32'hA5C3_1E7B, 5'd0, 2'b01, 32'hA5C3_1E7B);

        // ---- backpressure: 8 samples, 3-cycle stall once out_valid rises
        for (int i = 0; i < 8; i++) begin
            pa[i] = $urandom;
            ps[i] = 5'($urandom_range(0, 31));
            pm[i] = 2'($urandom_range(0, 3));
        end
        j = 0; stall_left = 0; seen = 0; cyc = 0; out0 = out_cnt;
        while (cyc < 60 && (j < 8 || exp_q.size() > 0)) begin
            if (!seen && out_valid) begin
                seen = 1;
                stall_left = 3;
                hold_b = b;
            end
            drive(j < 8, pa[j % 8], ps[j % 8], pm[j % 8], stall_left == 0);
            tick(acc);
            if (acc) j++;
            if (stall_left > 0) begin
                check("bp_in_ready", {31'b0, in_ready}, 32'h0);
                check("bp_b_hold", b, hold_b);
                stall_left--;
            end
            cyc++;
        end
        check("bp_out_count", out_cnt - out0, 32'd8);
        check("bp_empty", exp_q.size(), 32'h0);

        // ---- reset mid-flight
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, $urandom, 5'($urandom_range(0, 31)), 2'b10, 1'b1);
            tick(acc);
        end
        check("mid_vld_before", {31'b0, out_valid}, 32'h1);
        resetn = 1'b0;
        #1;
        check("mid_rst_vld", {31'b0, out_valid}, 32'h0);
        check("mid_rst_b", b, 32'h0);
        drive(1'b1, 32'h1234_5678, 5'd1, 2'b00, 1'b1);
        @(negedge clock);
        resetn = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 32'h0, 5'd0, 2'b00, 1'b1);
            tick(acc);
            check("mid_flushed", {31'b0, out_valid}, 32'h0);
        end
        single_latency("fresh", 32'h8765_4321, 5'd8, 2'b01, ref_shift(32'h8765_4321, 5'd8, 2'b01));

        // ---- random traffic against the reference model
        j = 0; cyc = 0; out0 = out_cnt;
        while (j < 1000 && cyc < 6000) begin
            ra = $urandom;
            drive($urandom_range(0, 9) < 7, ra, 5'($urandom_range(0, 31)),
                  2'($urandom_range(0, 3)), $urandom_range(0, 3) != 0);
            tick(acc);
            if (acc) j++;
            cyc++;
        end
        check("rand_accepted", j, 32'd1000);
        drain(50);
        check("rand_out_count", out_cnt - out0, 32'd1000);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
